// File: rtl/arm_scoreboard.sv
// arm_scoreboard: register-hazard scoreboard for a short ARM-like pipeline.
//
// Tracks the EX, MEM and WB stages that sit downstream of decode and decides
// every cycle whether the decoded (ID) instruction may advance or must be held.
// With FORWARD=1 only a load followed directly by a consumer is a hazard; with
// FORWARD=0 any in-flight writer of a read register is a hazard.
//
// Ports:
//   clk, rst_b               clock, asynchronous active-low reset
//   id_valid                 a decoded instruction is present
//   id_rd_we / id_rd_num     destination write enable / register number
//   id_is_load               instruction is a load
//   id_halted                instruction is SWI (halt)
//   id_read_mask             bit i qualifies read slot i
//   id_read_reg0..2          read register numbers
//   flush                    redirect: nothing issues this cycle
//   stall / issue            hold / advance the ID instruction
//   busy_vec                 one bit per register with an in-flight writer
//   halt_done                halt issued and pipeline drained (sticky)
//   stall_count              saturating count of stall cycles before halt
module arm_scoreboard #(
   parameter int unsigned FORWARD = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             id_valid,
   input  logic             id_rd_we,
   input  logic [3:0]       id_rd_num,
   input  logic             id_is_load,
   input  logic             id_halted,
   input  logic [2:0]       id_read_mask,
   input  logic [3:0]       id_read_reg0,
   input  logic [3:0]       id_read_reg1,
   input  logic [3:0]       id_read_reg2,
   input  logic             flush,
   output logic             stall,
   output logic             issue,
   output logic [15:0]      busy_vec,
   output logic             halt_done,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic       v;
      logic       we;
      logic [3:0] rd;
      logic       ld;
   } stage_t;

   stage_t ex_q, mem_q, wb_q, ex_d;
   stage_t stg [3];
   logic [3:0] rd_slot [3];
   logic [2:0] hit;
   logic hazard, in_ok;
   logic halt_pending_q, halt_pending_d;
   logic halt_done_q, halt_done_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic unused_ld;

   assign stg[0] = ex_q;
   assign stg[1] = mem_q;
   assign stg[2] = wb_q;
   assign rd_slot[0] = id_read_reg0;
   assign rd_slot[1] = id_read_reg1;
   assign rd_slot[2] = id_read_reg2;

   // Load flags of MEM/WB never matter: by then the data is forwardable.
   assign unused_ld = mem_q.ld ^ wb_q.ld;

   // Per-stage read/write match; unmasked slots are skipped entirely.
   always_comb begin
      hit = '0;
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 3; i++) begin
            if (id_read_mask[i] && stg[s].v && stg[s].we && (rd_slot[i] == stg[s].rd)) begin
               hit[s] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      if (FORWARD != 0) begin
         hazard = hit[0] & ex_q.ld;
      end else begin
         hazard = |hit;
      end
   end

   // rst_b gating keeps stall/issue low while reset is held.
   assign in_ok = rst_b & id_valid & ~flush;
   assign stall = in_ok & (hazard | halt_pending_q);
   assign issue = in_ok & ~hazard & ~halt_pending_q;

   always_comb begin
      busy_vec = '0;
      for (int s = 0; s < 3; s++) begin
         if (stg[s].v && stg[s].we) begin
            busy_vec[stg[s].rd] = 1'b1;
         end
      end
   end

   always_comb begin
      ex_d = '0;
      if (issue) begin
         ex_d = '{v: 1'b1, we: id_rd_we, rd: id_rd_num, ld: id_is_load};
      end
      halt_pending_d = halt_pending_q | (issue & id_halted);
      // Drained once the post-edge EX, MEM and WB are all empty.
      halt_done_d = halt_done_q | (halt_pending_d & ~ex_d.v & ~ex_q.v & ~mem_q.v);
      stall_count_d = stall_count_q;
      if (stall && !halt_pending_q && !(&stall_count_q)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ex_q           <= '0;
         mem_q          <= '0;
         wb_q           <= '0;
         halt_pending_q <= 1'b0;
         halt_done_q    <= 1'b0;
         stall_count_q  <= '0;
      end else begin
         ex_q           <= ex_d;
         mem_q          <= ex_q;
         wb_q           <= mem_q;
         halt_pending_q <= halt_pending_d;
         halt_done_q    <= halt_done_d;
         stall_count_q  <= stall_count_d;
      end
   end

   assign halt_done   = halt_done_q;
   assign stall_count = stall_count_q;

endmodule
